serial_adder_ctrl: RTL and testbench

Sequencer that adds two WIDTH-bit operands by time-sharing a single 2-bit adder slice, one 2-bit chunk per clock, LSB first, with a registered carry chain. Start/busy/done handshake in front; registered sum/cout behind. Used wherever wide additions are needed but only one 2-bit adder datapath is budgeted.

---
 rtl/serial_adder_ctrl_if.sv | 16 +
 rtl/serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_serial_adder_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the serial adder sequencer.
// The master drives start/a/b. The controller (slave) returns busy/done/sum/cout.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Adds two WIDTH-bit operands through one shared 2-bit adder slice, LSB chunk first.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   RUN   | one 2-bit chunk per edge, carry registered between chunks
//   DONE  | single-cycle done pulse; sum/cout were just loaded
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt, sum_q;
  logic             cout_q;
  logic [CW:0]      lsb;
  logic [2:0]       slice;
  logic             last_chunk;

  assign lsb        = {cnt, 1'b0};
  assign slice      = {1'b0, op_a[lsb +: 2]} + {1'b0, op_b[lsb +: 2]} + {2'b00, carry};
  assign last_chunk = (cnt == CW'(N - 1));

  // The final chunk must be merged combinationally so sum loads the complete result.
  always_comb begin
    acc_nxt            = acc;
    acc_nxt[lsb +: 2]  = slice[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= slice[2];
          if (last_chunk) begin
            cnt    <= '0;
            sum_q  <= acc_nxt;
            cout_q <= slice[2];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance for the handshake scenarios and a 4-bit
// instance for the exhaustive sweep, both compared against plain integer addition.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) if4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Starts one operation from a negedge in IDLE; lat counts edges including the accepting one
  // up to the edge that raises done. Returns at the negedge of the cycle after done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output logic [7:0] s,
                      output logic c, output int lat, output int busy_cnt,
                      output bit sum_early, output logic done_after);
    logic [7:0] prev_sum;
    prev_sum  = if8.sum;
    if8.a     = a;
    if8.b     = b;
    if8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if8.start = 1'b0;
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    lat = 1; busy_cnt = 0; sum_early = 1'b0;
    while (!if8.done && lat < 20) begin
      if (if8.busy) busy_cnt++;
      if (if8.sum !== prev_sum) sum_early = 1'b1;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    s = if8.sum;
    c = if8.cout;
    @(posedge clk); @(negedge clk);
    done_after = if8.done;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output logic [3:0] s,
                      output logic c, output int lat);
    if4.a     = a;
    if4.b     = b;
    if4.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if4.start = 1'b0;
    lat = 1;
    while (!if4.done && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    s = if4.sum;
    c = if4.cout;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    @(negedge clk); #2;
    checks++;
    if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b sum=%h cout=%b required all 0",
               if8.busy, if8.done, if8.sum, if8.cout);
    end
    checks++;
    if ({if4.busy, if4.done, if4.sum, if4.cout} !== 7'd0) begin
      errors++;
      $display("FAIL reset4 busy=%b done=%b sum=%h cout=%b required all 0",
               if4.busy, if4.done, if4.sum, if4.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", if8.busy, if8.done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s; logic c, da; int lat, bc; bit early;
    run8(8'h5A, 8'h3C, s, c, lat, bc, early, da);
    checks++;
    if ({c, s} !== 9'h096) begin
      errors++;
      $display("FAIL basic_sum got %b_%h required 0_96", c, s);
    end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d required 4", bc); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d required 5", lat); end
    checks++;
    if (early) begin errors++; $display("FAIL basic_sum_early got 1 required 0"); end
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b required 0", da); end
  endtask

  task automatic test_carry();
    logic [7:0] va [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'hFF, 8'h00, 8'h7F};
    logic [7:0] s; logic c, da; int lat, bc; bit early;
    for (int i = 0; i < 4; i++) begin
      run8(va[i], vb[i], s, c, lat, bc, early, da);
      checks++;
      if ({c, s} !== ref_add8(va[i], vb[i])) begin
        errors++;
        $display("FAIL carry_%0d got %b_%h required %h", i, c, s, ref_add8(va[i], vb[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, s; logic c, da; int lat, bc; bit early;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, s, c, lat, bc, early, da);
      checks++;
      if ({c, s} !== ref_add8(ra, rb) || lat !== 5) begin
        errors++;
        $display("FAIL random %h+%h got %b_%h lat %0d required %h lat 5",
                 ra, rb, c, s, lat, ref_add8(ra, rb));
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] ra, rb, s; logic c; int dones;
    ra = 8'($urandom); rb = 8'($urandom);
    if8.a = ra; if8.b = rb; if8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if8.a = 8'h11; if8.b = 8'h22;
    dones = 0; s = '0; c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (if8.done) begin dones++; s = if8.sum; c = if8.cout; end
      if (!if8.busy) if8.start = 1'b0;
      else begin if8.a = 8'($urandom); if8.b = 8'($urandom); end
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d required 1", dones); end
    checks++;
    if ({c, s} !== ref_add8(ra, rb)) begin
      errors++;
      $display("FAIL ignore_sum got %b_%h required %h", c, s, ref_add8(ra, rb));
    end
  endtask

  task automatic test_back_to_back();
    int last_done, ndone;
    last_done = -100; ndone = 0;
    if8.a = 8'h01; if8.b = 8'h02; if8.start = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == last_done + 1) begin
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle cyc %0d busy=%b done=%b required 0 0", cyc, if8.busy, if8.done);
        end
      end
      if (if8.done === 1'b1) begin
        checks++;
        if (cyc !== (ndone == 0 ? 4 : last_done + 6)) begin
          errors++;
          $display("FAIL b2b_spacing done at edge %0d previous %0d required period 6", cyc, last_done);
        end
        checks++;
        if ({if8.cout, if8.sum} !== ref_add8(8'h01, 8'h02)) begin
          errors++;
          $display("FAIL b2b_sum got %b_%h required 003", if8.cout, if8.sum);
        end
        last_done = cyc;
        ndone++;
      end
    end
    if8.start = 1'b0;
    checks++;
    if (ndone !== 3) begin errors++; $display("FAIL b2b_count got %0d required 3", ndone); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic c, da; int lat, bc, dones; bit early;
    run8(8'hFF, 8'hFF, s, c, lat, bc, early, da);
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if8.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset busy=%b done=%b sum=%h cout=%b required all 0",
               if8.busy, if8.done, if8.sum, if8.cout);
    end
    #1 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (if8.done || if8.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midrun_no_done got %0d active cycles required 0", dones); end
    run8(8'h80, 8'h80, s, c, lat, bc, early, da);
    checks++;
    if ({c, s} !== 9'h100 || lat !== 5) begin
      errors++;
      $display("FAIL midrun_fresh got %b_%h lat %0d required 1_00 lat 5", c, s, lat);
    end
  endtask

  task automatic test_sweep4();
    logic [3:0] s; logic c; int lat;
    logic [4:0] exp_v;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), s, c, lat);
        exp_v = 5'(a + b);
        checks++;
        if ({c, s} !== exp_v) begin
          errors++;
          $display("FAIL sweep4 %0d+%0d got %b_%h required %h", a, b, c, s, exp_v);
        end
        checks++;
        if (lat !== 3) begin
          errors++;
          $display("FAIL sweep4_latency %0d+%0d got %0d required 3", a, b, lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
